// File: rtl/pipe_stage_reg_if.sv
// Inter-stage pipeline bus: control/redirect inputs, payload in and registered payload out.
// The master drives the stage inputs; the slave is the stage register itself.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 31
);
    logic              Stall;
    logic              Flush;
    logic              Eret;
    logic [31:0]       EPC;
    logic [31:0]       InsIn;
    logic [31:0]       PCIn;
    logic [CTRL_W-1:0] CtrlIn;
    logic [4:0]        ExcIn;
    logic              BDIn;
    logic              ValidIn;
    logic [31:0]       InsOut;
    logic [31:0]       PCOut;
    logic [CTRL_W-1:0] CtrlOut;
    logic [4:0]        ExcOut;
    logic              BDOut;
    logic              ValidOut;

    modport master (
        output Stall, Flush, Eret, EPC, InsIn, PCIn, CtrlIn, ExcIn, BDIn, ValidIn,
        input  InsOut, PCOut, CtrlOut, ExcOut, BDOut, ValidOut
    );

    modport slave (
        input  Stall, Flush, Eret, EPC, InsIn, PCIn, CtrlIn, ExcIn, BDIn, ValidIn,
        output InsOut, PCOut, CtrlOut, ExcOut, BDOut, ValidOut
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core with flush, stall, ERET and fetch-fault check.
// Define PIPE_PERF_EN to add StallCnt/BubbleCnt performance counters.
module pipe_stage_reg #(
    parameter int          CTRL_W   = 31,
    parameter int          TNEW_LSB = 8,
    parameter int          TNEW_W   = 3,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFF,
    parameter bit          CHK_PC   = 1'b1,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic Clk,
    input  logic Reset,
`ifdef PIPE_PERF_EN
    output logic [31:0] StallCnt,
    output logic [31:0] BubbleCnt,
`endif
    pipe_stage_reg_if.slave bus
);
    typedef struct packed {
        logic [31:0]       ins;
        logic [31:0]       pc;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        exc;
        logic              bd;
        logic              vld;
    } stage_t;

    stage_t q;
    stage_t load;
    logic   fault;

    always_comb begin
        fault = CHK_PC && ((bus.PCIn[1:0] != 2'b00) || (bus.PCIn < PC_LO) || (bus.PCIn > PC_HI));
        load.pc  = bus.PCIn;
        load.bd  = bus.BDIn;
        load.vld = bus.ValidIn;
        if (fault) begin
            load.ins  = '0;
            load.ctrl = '0;
            load.exc  = EXC_ADEL;
        end else begin
            load.ins  = bus.InsIn;
            load.ctrl = bus.CtrlIn;
            load.exc  = bus.ExcIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || bus.Flush) begin
            q.ins  <= '0;
            q.pc   <= PC_RESET;
            q.ctrl <= '0;
            q.exc  <= '0;
            q.bd   <= 1'b0;
            q.vld  <= 1'b0;
        end else if (!bus.Stall) begin
            if (bus.Eret) begin
                q.ins  <= '0;
                q.pc   <= bus.EPC;
                q.ctrl <= '0;
                q.exc  <= '0;
                q.bd   <= 1'b0;
                q.vld  <= 1'b0;
            end else begin
                q <= load;
            end
        end
    end

    // Tnew counts down by one per stage, saturating at zero; aging is applied on the read side.
    logic [TNEW_W-1:0] tnew;
    always_comb begin
        tnew        = q.ctrl[TNEW_LSB +: TNEW_W];
        bus.CtrlOut = q.ctrl;
        if (tnew != '0)
            bus.CtrlOut[TNEW_LSB +: TNEW_W] = tnew - 1'b1;
    end

    assign bus.InsOut   = q.ins;
    assign bus.PCOut    = q.pc;
    assign bus.ExcOut   = q.exc;
    assign bus.BDOut    = q.bd;
    assign bus.ValidOut = q.vld;

`ifdef PIPE_PERF_EN
    // A bubble is any edge that writes a non-valid slot; faults count even when ValidIn is set.
    logic bubble;
    assign bubble = bus.Flush || (!bus.Stall && (bus.Eret || fault || !bus.ValidIn));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCnt  <= '0;
            BubbleCnt <= '0;
        end else begin
            if (bus.Stall && !bus.Flush)
                StallCnt <= StallCnt + 32'd1;
            if (bubble)
                BubbleCnt <= BubbleCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, load/aging, fetch faults, stall, flush, ERET, perf counters.
module tb_pipe_stage_reg;
    logic Clk = 1'b0;
    logic Reset;
    int   nvec = 0;
    int   nerr = 0;

    pipe_stage_reg_if #(.CTRL_W(31)) bus ();

`ifdef PIPE_PERF_EN
    logic [31:0] StallCnt, BubbleCnt;
    pipe_stage_reg dut (.Clk(Clk), .Reset(Reset), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt), .bus(bus));
`else
    pipe_stage_reg dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`endif

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic [30:0] ctrl,
                         input logic [4:0] exc, input logic bd, input logic vld);
        bus.PCIn = pc; bus.InsIn = ins; bus.CtrlIn = ctrl;
        bus.ExcIn = exc; bus.BDIn = bd; bus.ValidIn = vld;
    endtask

    initial begin
        Reset = 1'b1;
        bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Eret = 1'b0; bus.EPC = '0;
        drive(32'h0000_3004, 32'hDEAD_BEEF, 31'h0000_0215, 5'd3, 1'b1, 1'b1);
        step();
        chk("rst_pc",    bus.PCOut, 32'h0000_3000);
        chk("rst_ins",   bus.InsOut, 32'h0);
        chk("rst_ctrl",  {1'b0, bus.CtrlOut}, 32'h0);
        chk("rst_exc",   {27'h0, bus.ExcOut}, 32'h0);
        chk("rst_vld",   {31'h0, bus.ValidOut}, 32'h0);
        chk("rst_bd",    {31'h0, bus.BDOut}, 32'h0);

        Reset = 1'b0;
        drive(32'h0000_3004, 32'h2408_0005, 31'h0000_0215, 5'd0, 1'b1, 1'b1);
        step();
        chk("ld_ins",  bus.InsOut, 32'h2408_0005);
        chk("ld_ctrl", {1'b0, bus.CtrlOut}, 32'h0000_0115);
        chk("ld_pc",   bus.PCOut, 32'h0000_3004);
        chk("ld_bd",   {31'h0, bus.BDOut}, 32'h1);
        chk("ld_vld",  {31'h0, bus.ValidOut}, 32'h1);

        drive(32'h0000_3008, 32'h0000_0001, 31'h4000_0003, 5'd0, 1'b0, 1'b1);
        step();
        chk("tnew0_ctrl", {1'b0, bus.CtrlOut}, 32'h4000_0003);

        drive(32'h0000_3002, 32'h0000_1234, 31'h0000_0215, 5'd10, 1'b0, 1'b1);
        step();
        chk("mis_ins",  bus.InsOut, 32'h0);
        chk("mis_ctrl", {1'b0, bus.CtrlOut}, 32'h0);
        chk("mis_exc",  {27'h0, bus.ExcOut}, 32'h4);
        chk("mis_pc",   bus.PCOut, 32'h0000_3002);

        drive(32'h0000_7000, 32'h0000_1234, 31'h0000_0215, 5'd10, 1'b0, 1'b1);
        step();
        chk("hi_exc", {27'h0, bus.ExcOut}, 32'h4);
        chk("hi_ins", bus.InsOut, 32'h0);
        chk("hi_pc",  bus.PCOut, 32'h0000_7000);

        drive(32'h0000_2FFC, 32'h0000_1234, 31'h0000_0215, 5'd10, 1'b0, 1'b1);
        step();
        chk("lo_exc", {27'h0, bus.ExcOut}, 32'h4);

        drive(32'h0000_6FFC, 32'h0000_AAAA, 31'h0000_0700, 5'd10, 1'b0, 1'b1);
        step();
        chk("edge_ins",  bus.InsOut, 32'h0000_AAAA);
        chk("edge_exc",  {27'h0, bus.ExcOut}, 32'hA);
        chk("edge_ctrl", {1'b0, bus.CtrlOut}, 32'h0000_0600);

        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_3100 + 32'(i * 4), 32'h0000_5550 + 32'(i), 31'h0000_0300, 5'd0, 1'b1, 1'b0);
            step();
            chk("stl_pc",   bus.PCOut, 32'h0000_6FFC);
            chk("stl_ins",  bus.InsOut, 32'h0000_AAAA);
            chk("stl_ctrl", {1'b0, bus.CtrlOut}, 32'h0000_0600);
        end
        bus.Flush = 1'b1;
        step();
        chk("sfl_pc",  bus.PCOut, 32'h0000_3000);
        chk("sfl_ins", bus.InsOut, 32'h0);
        chk("sfl_exc", {27'h0, bus.ExcOut}, 32'h0);
        chk("sfl_vld", {31'h0, bus.ValidOut}, 32'h0);

        bus.Stall = 1'b0; bus.Flush = 1'b0;
        drive(32'h0000_3010, 32'h0000_0011, 31'h0000_0000, 5'd0, 1'b1, 1'b1);
        step();
        chk("re_ins", bus.InsOut, 32'h0000_0011);

        bus.Eret = 1'b1; bus.EPC = 32'h0000_3400;
        step();
        chk("eret_pc",  bus.PCOut, 32'h0000_3400);
        chk("eret_ins", bus.InsOut, 32'h0);
        chk("eret_vld", {31'h0, bus.ValidOut}, 32'h0);
        chk("eret_bd",  {31'h0, bus.BDOut}, 32'h0);

        bus.Eret = 1'b0;
        drive(32'h0000_3020, 32'h0000_0022, 31'h0000_0000, 5'd0, 1'b0, 1'b1);
        step();
        bus.Eret = 1'b1; bus.Stall = 1'b1; bus.EPC = 32'h0000_3500;
        step();
        chk("erst_pc",  bus.PCOut, 32'h0000_3020);
        chk("erst_ins", bus.InsOut, 32'h0000_0022);
        chk("erst_vld", {31'h0, bus.ValidOut}, 32'h1);

        bus.Eret = 1'b0; bus.Stall = 1'b0;
        drive(32'h0000_3024, 32'h0000_0033, 31'h0000_0000, 5'd0, 1'b0, 1'b0);
        step();
        chk("nv_vld", {31'h0, bus.ValidOut}, 32'h0);
        chk("nv_pc",  bus.PCOut, 32'h0000_3024);

`ifdef PIPE_PERF_EN
        Reset = 1'b1;
        step();
        chk("pf_rst_s", StallCnt, 32'd0);
        chk("pf_rst_b", BubbleCnt, 32'd0);
        Reset = 1'b0;
        drive(32'h0000_3030, 32'h0000_0044, 31'h0000_0000, 5'd0, 1'b0, 1'b1);
        step();
        bus.Stall = 1'b1;
        repeat (5) step();
        chk("pf_stall", StallCnt, 32'd5);
        chk("pf_b0",    BubbleCnt, 32'd0);
        bus.Stall = 1'b0; bus.Flush = 1'b1;
        step();
        chk("pf_fl_s", StallCnt, 32'd5);
        chk("pf_fl_b", BubbleCnt, 32'd1);
        bus.Flush = 1'b0; bus.Eret = 1'b1;
        step();
        chk("pf_er_s", StallCnt, 32'd5);
        chk("pf_er_b", BubbleCnt, 32'd2);
        bus.Eret = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
